// File: rtl/flick_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flick_pkg
// Purpose  : Shared state encoding and default timing constants for the
//            button conditioner.
// Revision : 1.0 - initial release
// ============================================================================
package flick_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_LONG_CYCLES     = 64;
    localparam int DEF_CNT_W           = 8;

endpackage : flick_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : 1-bit two-flop synchronizer for asynchronous board inputs.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/flick_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : flick_conditioner
// Purpose  : Debounces a raw push-button into a one-cycle flick pulse, a
//            debounced level, a long-press pulse and a wrapping press count.
// Revision : 1.0 - initial release
// ============================================================================
module flick_conditioner
    import flick_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       flick,
    output logic       btn_level,
    output logic       long_press,
    output logic [7:0] press_cnt,
    output logic [1:0] current_state
);

    localparam logic [CNT_W-1:0] c_DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_LONG      = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic             w_btn_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_flick;
    logic             r_level;
    logic             r_long;
    logic [7:0]       r_press_cnt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (btn_raw),
        .o_q (w_btn_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_deb_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_flick     <= 1'b0;
            r_level     <= 1'b0;
            r_long      <= 1'b0;
            r_press_cnt <= 8'd0;
        end else begin
            r_flick <= 1'b0;
            r_long  <= 1'b0;

            // Hold timer spans release bounces so a brief dip does not restart it
            if ((r_state == PRESSED || r_state == RELEASE_WAIT) && (r_hold_cnt < c_LONG)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
                r_long     <= (r_hold_cnt == c_LONG_LAST);
            end

            case (r_state)
                IDLE: begin
                    if (w_btn_sync) begin
                        r_state   <= PRESS_WAIT;
                        r_deb_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_btn_sync) begin
                        r_state <= IDLE;
                    end else if (r_deb_cnt == c_DEB_LAST) begin
                        r_state     <= PRESSED;
                        r_flick     <= 1'b1;
                        r_level     <= 1'b1;
                        r_press_cnt <= r_press_cnt + 8'd1;
                        r_hold_cnt  <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_btn_sync) begin
                        r_state   <= RELEASE_WAIT;
                        r_deb_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (w_btn_sync) begin
                        r_state <= PRESSED;
                    end else if (r_deb_cnt == c_DEB_LAST) begin
                        r_state <= IDLE;
                        r_level <= 1'b0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign flick         = r_flick;
    assign btn_level     = r_level;
    assign long_press    = r_long;
    assign press_cnt     = r_press_cnt;
    assign current_state = r_state;

endmodule : flick_conditioner
`default_nettype wire
